// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: word-aligned req/ack fetch into a small prefetch queue that feeds decode
// over valid/ready. A taken redirect flushes the queue and restarts fetch at the new target.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [0:0] {
        StFetch,
        StDiscard
    } state_e;

    state_e          state_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     pending_pc_q;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic [31:0]     target;
    logic            push;
    logic            pop;

    always_comb begin
        target = redirect_pc & ~32'd3;
        if (reset) begin
            imem_req = 1'b0;
        end else if (state_q == StDiscard) begin
            // Hold the stale request until memory acknowledges it.
            imem_req = 1'b1;
        end else begin
            imem_req = (count_q < FULL_COUNT);
        end
        imem_addr = fetch_pc_q;
        push      = imem_req & imem_ack & ~redirect & (state_q == StFetch);
        pop       = inst_valid & inst_ready & ~redirect;
    end

    assign inst_valid = (count_q != '0);
    assign inst_out   = inst_valid ? inst_mem[head_q] : 32'd0;
    assign inst_pc    = inst_valid ? pc_mem[head_q]   : 32'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= fetch_pc_q;
            inst_mem[tail_q] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StFetch;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= 32'd0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            if (redirect) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + 1'b1;
                if (pop)  head_q <= head_q + 1'b1;
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
            end

            case (state_q)
                StFetch: begin
                    if (redirect) begin
                        // An unacked request must stay stable, so park the target instead.
                        if (imem_req && !imem_ack) begin
                            state_q      <= StDiscard;
                            pending_pc_q <= target;
                        end else begin
                            fetch_pc_q <= target;
                        end
                    end else if (push) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                    end
                end
                StDiscard: begin
                    if (imem_ack) begin
                        fetch_pc_q <= redirect ? target : pending_pc_q;
                        state_q    <= StFetch;
                    end else if (redirect) begin
                        pending_pc_q <= target;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage with a small prefetch queue, sitting directly upstream of decode, control and register read in the RISC-V core. It generates word-aligned fetch addresses to the instruction memory over a req/ack handshake and buffers returned words with their PCs. It presents them to decode over a valid/ready handshake. On a taken branch or jump, the queue is flushed and fetch restarts at the redirect target.

## Interface
- DEPTH, 4: prefetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h00000000: first fetch address after reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; bits [1:0] always 0.
- imem_ack  in  1  memory has accepted the request and `imem_rdata` is valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- redirect  in  1  a branch or jump was taken; flush and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode consumes the head this cycle.
- inst_out  out  32  head instruction; 0 when `inst_valid`=0.
- inst_pc  out  32  PC of the head instruction; 0 when `inst_valid`=0.

## Operation
- **State: queue**
  - DEPTH entries of {pc, inst}, plus a head pointer, a tail pointer and a count (0..DEPTH).
  - A push and a pop in the same cycle leave the count unchanged.
- **State: fetch_pc** holds the address to request next.
- **State: pending_pc** holds a redirect target captured while a discard is in progress.
- **FSM states:** FETCH and DISCARD.
- **FETCH**
  - `imem_req` = (count < DEPTH) and not reset; `imem_addr` = fetch_pc.
  - On req&ack without redirect: push {fetch_pc, imem_rdata}, then fetch_pc += 4.
  - PC arithmetic is modulo 2^32, so 32'hFFFFFFFC wraps to 0.
- **Request stability**
  - Once raised, `imem_req` and `imem_addr` stay stable until ack.
  - This holds by construction: count cannot rise while a request is outstanding.
- **Pop** occurs on `inst_valid` & `inst_ready`.
- **Redirect in FETCH**
  - Always: the queue is flushed (count=0, pointers reset) and any pop that cycle is cancelled.
  - If the request is outstanding (req=1, ack=0): go to DISCARD and set pending_pc = redirect_pc & ~3. fetch_pc is left unchanged, so the address stays stable.
  - Otherwise (no request, or req&ack this cycle): any acked data is dropped, fetch_pc = redirect_pc & ~3, and the FSM stays in FETCH.
- **DISCARD**
  - `imem_req`=1 and `imem_addr`=fetch_pc, i.e. the stale request is held.
  - On ack: drop the data, fetch_pc = pending_pc, go to FETCH.
  - A redirect in DISCARD flushes the queue again and overwrites pending_pc. If it coincides with ack, the new target is loaded into fetch_pc directly.
  - No pushes occur in DISCARD.
- **Priority:** reset > redirect > push/pop.

## Timing
- **Reset values** (the cycle after reset is sampled high):
  - state = FETCH, fetch_pc = RESET_PC, queue empty.
  - `inst_valid`=0, `inst_out`=0, `inst_pc`=0.
  - `imem_req`=0 while reset is high; `imem_addr`=RESET_PC.
- **Reset mid-request:** reset while a request is outstanding abandons it. A late ack is ignored unless `imem_req` is high.
- **First request:** the first cycle after reset deasserts has `imem_req`=1 at RESET_PC.
- **Fetch latency:** ack in cycle N gives `inst_valid`=1 with that word in cycle N+1. The queue is registered; there is no combinational ack→valid path.
- **Throughput:** with same-cycle ack and `inst_ready`=1, one instruction per cycle, sustained.
- **Redirect latency:** redirect in cycle N gives `inst_valid`=0 in N+1.
  - No outstanding request: `imem_addr`=target in N+1.
  - Outstanding request: `imem_addr`=target in the cycle after the stale ack.
- **Backpressure:**
  - Queue full with `inst_ready`=0: `imem_req`=0 and fetch_pc holds.
  - A pop on a full queue re-enables `imem_req` the next cycle.
- **Output paths:** `inst_valid`, `inst_out` and `inst_pc` depend only on registered state. `imem_req` depends on state, count and reset.

## Test plan
- **Streaming:** reset, then memory acks every cycle returning the address as data, with `inst_ready`=1. Required: `inst_pc`=0,4,8,... on consecutive cycles from 2 cycles after reset release; `inst_out`==`inst_pc`; no gaps.
- **Backpressure/full:** `inst_ready`=0 for 10 cycles with immediate ack. Required: `imem_req` drops after 4 pushes; queue holds PCs 0..C; a single pop re-issues at 0x10 the next cycle.
- **Redirect, idle memory:** at a steady stream, pulse `redirect` with redirect_pc=0x103. Required: next cycle `inst_valid`=0 and `imem_addr`=0x100; the first delivered `inst_pc`=0x100.
- **Redirect during outstanding request:** ack delayed 3 cycles at addr 0x20; redirect to 0x80 in the first wait cycle. Required: `imem_addr` stays 0x20 until ack; the 0x20 data is never presented; the next request is 0x80.
- **Double redirect and coincident ack:** in DISCARD, redirect to 0x40, then redirect to 0x60 in the ack cycle. Required: the next request is 0x60 and no stale instruction is presented.
- **Wrap and reset mid-operation:** set RESET_PC=0xFFFFFFF8 and stream. Required: PCs F8, FC, 0, 4. Then assert reset with a request outstanding. Required: next cycle `inst_valid`=0, `imem_req`=0; after release, fetch restarts at 0xFFFFFFF8.
